// File: rtl/prog_loader.sv
// Boot-time program loader for the SAP-1 core: streams an image into the 16x8 program RAM,
// holds the CPU in reset while loading, then reports halt. Optional macro PROG_LOADER_ZERO_FILL_EN.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic              hltn_i,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_SETTLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_cpu_rstn;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_cpu_rstn_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_ready;
  logic                w_xfer;
  logic                w_terminal;

  assign w_ready    = (r_state == S_LOAD);
  assign w_xfer     = w_ready && valid_i;
  assign w_terminal = (r_cnt == LAST_ADDR);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cpu_rstn <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_cpu_rstn <= w_cpu_rstn_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_xfer && (w_terminal || last_i)) begin
`ifdef PROG_LOADER_ZERO_FILL_EN
          w_state_nxt = w_terminal ? S_SETTLE : S_FILL;
`else
          w_state_nxt = S_SETTLE;
`endif
        end
      end
`ifdef PROG_LOADER_ZERO_FILL_EN
      S_FILL:   if (w_terminal) w_state_nxt = S_SETTLE;
`else
      S_FILL:   w_state_nxt = S_SETTLE;
`endif
      S_SETTLE: w_state_nxt = S_RUN;
      S_RUN: begin
        if (start_i)     w_state_nxt = S_LOAD;
        else if (!hltn_i) w_state_nxt = S_HALT;
      end
      S_HALT: if (start_i) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are derived from the upcoming state so they line up with it.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_we_nxt   = 1'b0;
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    case (r_state)
      S_IDLE: if (start_i) w_cnt_nxt = '0;
      S_LOAD: begin
        if (w_xfer) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = r_cnt;
          w_data_nxt = data_i;
          if (!w_terminal) w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
`ifdef PROG_LOADER_ZERO_FILL_EN
      S_FILL: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        if (!w_terminal) w_cnt_nxt = r_cnt + ADDR_W'(1);
      end
`endif
      S_RUN, S_HALT: if (start_i) w_cnt_nxt = '0;
      default: ;
    endcase
    w_cpu_rstn_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_HALT);
    w_done_nxt     = (w_state_nxt == S_HALT);
    w_busy_nxt     = (w_state_nxt == S_LOAD) || (w_state_nxt == S_FILL) ||
                     (w_state_nxt == S_SETTLE);
  end

  assign ready_o    = w_ready;
  assign ram_we_o   = r_we;
  assign ram_addr_o = r_addr;
  assign ram_data_o = r_data;
  assign cpu_rstn_o = r_cpu_rstn;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule
